// File: rtl/bus_pkg.sv
// Shared types and constants for the BARQ/BAGD bus master port.
// MAX_RETRY is only referenced when BUS_MASTER_RETRY_EN is defined.
package bus_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 16;

  localparam logic [1:0] MAX_RETRY = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_cmd_t;

  // Watchdog counters must be able to hold their own timeout value.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Clear has priority over enable; the count stops at MAX.
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/bus_master_port.sv
// Initiator endpoint of the BARQ/BAGD shared-bus handshake: one command in,
// one response out. Define BUS_MASTER_RETRY_EN to retry error/strobe-timeout aborts.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_W         = BUS_ADDR_W,
  parameter int DATA_W         = BUS_DATA_W,
  parameter int GRANT_TIMEOUT  = 32,
  parameter int STROBE_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              barq_o,
  input  logic              bagd_i,
  input  logic              target_ready_i,
  input  logic              data_strobe_i,
  input  logic              error_i,
  output logic              bus_oe_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic              bus_we_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int GW = cnt_width(GRANT_TIMEOUT);
  localparam int SW = cnt_width(STROBE_TIMEOUT);
  localparam logic [GW-1:0] GRANT_LAST  = GW'(GRANT_TIMEOUT - 1);
  localparam logic [SW-1:0] STROBE_LAST = SW'(STROBE_TIMEOUT - 1);

  state_t   state;
  bus_cmd_t cmd_q;
  logic     bagd_low_q;

  logic [GW-1:0] grant_cnt;
  logic [SW-1:0] strobe_cnt;

  logic grant_to;
  logic strobe_to;
  logic grant_lost;
  logic xfer_fail;
  logic do_retry;
  logic retry_pend;

  // Both watchdogs restart from zero every time their state is (re)entered.
  sat_counter #(.WIDTH(GW), .MAX(GRANT_TIMEOUT)) u_grant_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != REQ),
    .en    (state == REQ),
    .count (grant_cnt)
  );

  sat_counter #(.WIDTH(SW), .MAX(STROBE_TIMEOUT)) u_strobe_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != XFER),
    .en    ((state == XFER) && target_ready_i),
    .count (strobe_cnt)
  );

  assign grant_to   = (grant_cnt == GRANT_LAST);
  assign strobe_to  = target_ready_i && (strobe_cnt == STROBE_LAST);
  assign grant_lost = !bagd_i && bagd_low_q;
  assign xfer_fail  = error_i || grant_lost || strobe_to;

`ifdef BUS_MASTER_RETRY_EN
  logic [1:0] retry_cnt_q;

  // Lost grant and grant timeout are not worth retrying; the arbiter is gone.
  assign do_retry = (error_i || strobe_to) && (retry_cnt_q < MAX_RETRY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt_q <= '0;
      retry_pend  <= 1'b0;
    end else if ((state == IDLE) && cmd_valid_i) begin
      retry_cnt_q <= '0;
      retry_pend  <= 1'b0;
    end else if ((state == XFER) && !data_strobe_i && xfer_fail && do_retry) begin
      retry_cnt_q <= retry_cnt_q + 2'd1;
      retry_pend  <= 1'b1;
    end else if (state == DONE) begin
      retry_pend  <= 1'b0;
    end
  end
`else
  assign do_retry   = 1'b0;
  assign retry_pend = 1'b0;
`endif

  // Bus drivers are parked at zero whenever the port does not own the bus.
  assign bus_addr_o  = bus_oe_o ? cmd_q.addr  : '0;
  assign bus_wdata_o = bus_oe_o ? cmd_q.wdata : '0;
  assign bus_we_o    = bus_oe_o & cmd_q.we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_q       <= '0;
      bagd_low_q  <= 1'b0;
      cmd_ready_o <= 1'b1;
      barq_o      <= 1'b0;
      bus_oe_o    <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            cmd_q       <= '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
            state       <= REQ;
            barq_o      <= 1'b1;
            cmd_ready_o <= 1'b0;
          end
        end
        REQ: begin
          if (bagd_i) begin
            state      <= XFER;
            bus_oe_o   <= 1'b1;
            bagd_low_q <= 1'b0;
          end else if (grant_to) begin
            state       <= DONE;
            barq_o      <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
          end
        end
        XFER: begin
          // Request and drive enable drop on the edge that sees the terminating event.
          if (data_strobe_i) begin
            state       <= DONE;
            barq_o      <= 1'b0;
            bus_oe_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= cmd_q.we ? '0 : bus_rdata_i;
          end else if (xfer_fail) begin
            state    <= DONE;
            barq_o   <= 1'b0;
            bus_oe_o <= 1'b0;
            if (!do_retry) begin
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
            end
          end else begin
            bagd_low_q <= !bagd_i;
          end
        end
        DONE: begin
          if (retry_pend) begin
            state  <= REQ;
            barq_o <= 1'b1;
          end else begin
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: a reactive arbiter/target agent plus a timeline
// model predicting response cycle, error flag, read data and request count.
module tb_bus_master_port;

  localparam int GT    = 32;
  localparam int ST    = 16;
  localparam int NEVER = 100000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [15:0] cmd_addr_i = '0;
  logic [15:0] cmd_wdata_i = '0;
  logic        barq_o;
  logic        bagd_i = 1'b0;
  logic        target_ready_i = 1'b0;
  logic        data_strobe_i = 1'b0;
  logic        error_i = 1'b0;
  logic        bus_oe_o;
  logic [15:0] bus_addr_o;
  logic        bus_we_o;
  logic [15:0] bus_wdata_o;
  logic [15:0] bus_rdata_i = '0;
  logic        rsp_valid_o;
  logic [15:0] rsp_rdata_o;
  logic        rsp_err_o;

  int checks = 0;
  int errors = 0;

  bus_master_port #(
    .ADDR_W(16), .DATA_W(16), .GRANT_TIMEOUT(GT), .STROBE_TIMEOUT(ST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .barq_o(barq_o), .bagd_i(bagd_i), .target_ready_i(target_ready_i),
    .data_strobe_i(data_strobe_i), .error_i(error_i),
    .bus_oe_o(bus_oe_o), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk = ~clk;

  function automatic int tr_at(input logic [63:0] p, input int i);
    if (i < 64) return int'(p[i]);
    return 1;
  endfunction

  function automatic int min4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    if (d < m) m = d;
    return m;
  endfunction

  // Timeline model. Cycle 0 = command presented, request rises in cycle 1.
  // Within an attempt starting at s: grant seen at s+gd, bus owned from s+gd+1;
  // index t of the first terminating event in the owned window ends it at +t+1.
  task automatic model(input logic we, input logic [15:0] rd, input int gd, input int sd,
                       input int ed, input int gl, input logic [63:0] trp,
                       output int cyc, output int att, output logic err,
                       output logic [15:0] rdata);
    int s, x, t, tmo, ones, lost;
    s = 1; att = 0; err = 1'b1; rdata = '0; cyc = 0;
    tmo = 0;
    ones = tr_at(trp, 0);
    while (ones < ST) begin
      tmo++;
      ones += tr_at(trp, tmo);
    end
    lost = (gl >= NEVER) ? NEVER : gl + 1;
    for (int a = 1; a <= 3; a++) begin
      att = a;
      if (gd >= GT) begin
        cyc = s + GT; err = 1'b1;
        return;
      end
      x = s + 1 + gd;
      t = min4(sd, ed, lost, tmo);
      cyc = x + t + 1;
      if (sd == t) begin
        err = 1'b0;
        rdata = we ? 16'h0000 : rd;
        return;
      end
      err = 1'b1;
`ifdef BUS_MASTER_RETRY_EN
      if (((ed == t) || (tmo == t)) && (a < 3)) begin
        s = x + t + 2;
        continue;
      end
`endif
      return;
    end
  endtask

  task automatic run_txn(input string name, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rd,
                         input int gd, input int sd, input int ed, input int gl,
                         input logic [63:0] trp, input bit junk);
    int exp_cyc, exp_att, cyc, att, rq, xi;
    logic exp_err;
    logic [15:0] exp_rd;
    bit done, bus_ok, busy_ok, prev_barq;
    logic got_err, got_barq, got_oe;
    logic [15:0] got_rd;
    model(we, rd, gd, sd, ed, gl, trp, exp_cyc, exp_att, exp_err, exp_rd);
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL %s ready_idle got %0b want 1", name, cmd_ready_o);
    end
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_wdata_i = wdata;
    @(posedge clk); #1;
    cyc = 1; att = 0; rq = 0; xi = 0; done = 0; bus_ok = 1; busy_ok = 1; prev_barq = 0;
    got_err = 1'b0; got_barq = 1'b0; got_oe = 1'b0; got_rd = '0;
    cmd_valid_i = junk; cmd_we_i = 1'($urandom);
    cmd_addr_i = 16'($urandom); cmd_wdata_i = 16'($urandom);
    while (!done && cyc < 3000) begin
      if (cmd_ready_o !== 1'b0) busy_ok = 0;
      if (barq_o && !prev_barq) begin
        att++; rq = 0; xi = 0;
      end
      prev_barq = barq_o;
      if (rsp_valid_o) begin
        done = 1;
        got_err = rsp_err_o; got_rd = rsp_rdata_o; got_barq = barq_o; got_oe = bus_oe_o;
        cmd_valid_i = 1'b0; bagd_i = 1'b0; data_strobe_i = 1'b0; error_i = 1'b0;
      end else if (bus_oe_o) begin
        if (bus_addr_o !== addr || bus_wdata_o !== wdata || bus_we_o !== we || barq_o !== 1'b1)
          bus_ok = 0;
        target_ready_i = (tr_at(trp, xi) != 0);
        data_strobe_i  = (xi == sd);
        error_i        = (xi == ed);
        bagd_i         = !((xi == gl) || (xi == gl + 1));
        bus_rdata_i    = (xi == sd) ? rd : 16'($urandom);
        xi++;
      end else if (barq_o) begin
        bagd_i = (rq >= gd); rq++;
        data_strobe_i = 1'b0; error_i = 1'b0;
        target_ready_i = 1'($urandom); bus_rdata_i = 16'($urandom);
      end else begin
        bagd_i = 1'b0; data_strobe_i = 1'b0; error_i = 1'b0;
      end
      if (!done) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s no_response got none want cycle %0d", name, exp_cyc);
      return;
    end
    checks++;
    if (cyc != exp_cyc) begin
      errors++; $display("FAIL %s rsp_cycle got %0d want %0d", name, cyc, exp_cyc);
    end
    checks++;
    if (got_err !== exp_err) begin
      errors++; $display("FAIL %s rsp_err got %0b want %0b", name, got_err, exp_err);
    end
    checks++;
    if (got_rd !== exp_rd) begin
      errors++; $display("FAIL %s rsp_rdata got %h want %h", name, got_rd, exp_rd);
    end
    checks++;
    if (att != exp_att) begin
      errors++; $display("FAIL %s barq_attempts got %0d want %0d", name, att, exp_att);
    end
    checks++;
    if (got_barq !== 1'b0 || got_oe !== 1'b0) begin
      errors++; $display("FAIL %s released_at_rsp got barq %0b oe %0b want 0 0", name, got_barq, got_oe);
    end
    checks++;
    if (!bus_ok) begin
      errors++; $display("FAIL %s bus_drive got wrong addr/data/we want %h/%h/%0b", name, addr, wdata, we);
    end
    checks++;
    if (!busy_ok) begin
      errors++; $display("FAIL %s ready_busy got 1 want 0", name);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL %s after_rsp got valid %0b ready %0b want 0 1", name, rsp_valid_o, cmd_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cmd_ready_o !== 1'b1 || barq_o !== 1'b0 || bus_oe_o !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got ready %0b barq %0b oe %0b want 1 0 0", cmd_ready_o, barq_o, bus_oe_o);
    end
    checks++;
    if (rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 16'h0) begin
      errors++; $display("FAIL reset_rsp got valid %0b err %0b rdata %h want 0 0 0000", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    checks++;
    if (bus_addr_o !== 16'h0 || bus_wdata_o !== 16'h0 || bus_we_o !== 1'b0) begin
      errors++; $display("FAIL reset_bus got addr %h wdata %h we %0b want 0", bus_addr_o, bus_wdata_o, bus_we_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    run_txn("write", 1'b1, 16'h0012, 16'hBEEF, 16'h1234, 2, 4, NEVER, NEVER, {64{1'b1}}, 1'b0);
  endtask

  task automatic test_read();
    run_txn("read", 1'b0, 16'h0100, 16'h0000, 16'h5A5A, 1, 3, NEVER, NEVER, {64{1'b1}}, 1'b0);
  endtask

  task automatic test_grant_timeout();
    run_txn("grant_timeout", 1'b0, 16'h0400, 16'h0000, 16'h1111, NEVER, 0, NEVER, NEVER, {64{1'b1}}, 1'b0);
  endtask

  task automatic test_bus_error();
    run_txn("bus_error", 1'b1, 16'h0220, 16'hCAFE, 16'h0000, 1, NEVER, 2, NEVER, {64{1'b1}}, 1'b0);
  endtask

  task automatic test_strobe_and_error();
    run_txn("strobe_and_error", 1'b0, 16'h0330, 16'h0000, 16'hA5C3, 0, 3, 3, NEVER, {64{1'b1}}, 1'b0);
  endtask

  task automatic test_strobe_timeout();
    run_txn("strobe_timeout", 1'b0, 16'h0440, 16'h0000, 16'h2222, 3, NEVER, NEVER, NEVER,
            64'hF0F0_F0F0_3C3C_A5A5, 1'b0);
  endtask

  task automatic test_lost_grant();
    run_txn("lost_grant", 1'b1, 16'h0550, 16'h7777, 16'h0000, 1, 8, NEVER, 2, {64{1'b1}}, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_txn("back_to_back", 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), NEVER, NEVER,
              {64{1'b1}}, 1'b1);
  endtask

  task automatic test_random();
    int gd, sd, ed, gl;
    logic [63:0] trp;
    for (int i = 0; i < 40; i++) begin
      gd  = int'($urandom_range(0, 36));
      sd  = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 20));
      ed  = ($urandom_range(0, 1) == 0) ? NEVER : int'($urandom_range(0, 20));
      gl  = ($urandom_range(0, 4) != 0) ? NEVER : int'($urandom_range(0, 20));
      trp = {$urandom, $urandom} | {$urandom, $urandom};
      run_txn("random", 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              gd, sd, ed, gl, trp, 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit quiet;
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 16'h3333; cmd_wdata_i = 16'h0;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0; bagd_i = 1'b1; target_ready_i = 1'b1;
    n = 0;
    while (bus_oe_o !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus_oe_o !== 1'b1) begin
      errors++; $display("FAIL reset_mid_xfer got oe %0b want 1", bus_oe_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (barq_o !== 1'b0 || bus_oe_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async got barq %0b oe %0b valid %0b want 0 0 0", barq_o, bus_oe_o, rsp_valid_o);
    end
    bagd_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    quiet = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (rsp_valid_o !== 1'b0 || barq_o !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet || cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_mid_release got quiet %0b ready %0b want 1 1", quiet, cmd_ready_o);
    end
    run_txn("after_reset", 1'b1, 16'h0AB0, 16'h1357, 16'h0000, 2, 2, NEVER, NEVER, {64{1'b1}}, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_grant_timeout();
    test_bus_error();
    test_strobe_and_error();
    test_strobe_timeout();
    test_lost_grant();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
